// File: rtl/vscale_share_unmask_pkg.sv
// Shared vscale constants for the share unmask block.
// Default share width and share count.
package vscale_share_unmask_pkg;

  localparam int VSCALE_DWIDTH = 32;
  localparam int VSCALE_SHARES = 2;

endpackage

// File: rtl/vscale_share_xor_reduce.sv
// Combinational recombination of Boolean shares.
// Fed only from registered shares, never from raw inputs.
module vscale_share_xor_reduce
  import vscale_share_unmask_pkg::*;
#(
  parameter int DWIDTH = VSCALE_DWIDTH,
  parameter int SHARES = VSCALE_SHARES
) (
  input  logic [DWIDTH*SHARES-1:0] shares,
  output logic [DWIDTH-1:0]        word
);

  // XOR every share into one word
  always_comb begin
    word = '0;
    for (int i = 0; i < SHARES; i++) begin
      word = word ^ shares[i*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: rtl/vscale_share_unmask.sv
// Two-stage share unmask: S1 holds shares, S2 holds
// the recombined word. Empty stages hold zero.
module vscale_share_unmask
  import vscale_share_unmask_pkg::*;
#(
  parameter int DWIDTH = VSCALE_DWIDTH,
  parameter int SHARES = VSCALE_SHARES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DWIDTH*SHARES-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DWIDTH-1:0]        out_data
);

  logic                     s1_valid;
  logic [DWIDTH*SHARES-1:0] s1_data;
  logic                     s2_valid;
  logic [DWIDTH-1:0]        s2_data;
  logic [DWIDTH-1:0]        s1_word;
  logic                     s1_adv;
  logic                     accept;

  vscale_share_xor_reduce #(
    .DWIDTH(DWIDTH),
    .SHARES(SHARES)
  ) u_reduce (
    .shares(s1_data),
    .word  (s1_word)
  );

  // Handshake: S1 drains when S2 is free or being consumed
  always_comb begin
    s1_adv   = s1_valid && (!s2_valid || out_ready);
    in_ready = !flush && (!s1_valid || s1_adv);
    accept   = in_valid && in_ready;
  end

  // S1 share barrier; zeroed whenever it holds nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
    end else if (s1_adv || !s1_valid) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end
  end

  // S2 recombined word; zeroed whenever it holds nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= s1_word;
    end else if (out_ready || !s2_valid) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

endmodule
